// File: rtl/if_fetch_buf.sv
// Decoupled instruction-fetch front end: issues sequential fetches to a variable-latency memory,
// buffers in-order responses with their PCs for decode, and drains stale responses after a redirect.
module if_fetch_buf #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic             run_q;
  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;  // allocated and not yet consumed
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;    // allocated and not yet filled
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;    // in-flight responses owed to a flushed stream
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  pc_d   [DEPTH];
  logic [ILEN-1:0]  data_q [DEPTH];
  logic [ILEN-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [CNT_W-1:0] used;
  logic             req_fire;
  logic             inst_fire;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_owed;

  assign used          = alloc_cnt_q + drop_cnt_q;
  assign mem_req_valid = run_q & (used < DEPTH_C) & ~redirect_valid;
  assign mem_req_addr  = fpc_q;
  assign inst_valid    = filled_q[head_q];
  assign inst          = data_q[head_q];
  assign inst_pc       = pc_q[head_q];

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign inst_fire = inst_valid & inst_ready;
  assign rsp_owed  = (drop_cnt_q != '0) | (pend_cnt_q != '0);
  assign rsp_drop  = mem_rsp_valid & (drop_cnt_q != '0);
  assign rsp_fill  = mem_rsp_valid & (drop_cnt_q == '0) & (pend_cnt_q != '0);

  // NOTE: every target gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    fpc_d       = fpc_q;
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    head_d      = head_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    pc_d        = pc_q;
    data_d      = data_q;
    filled_d    = filled_q;

    if (redirect_valid) begin
      // Unfilled entries become responses to discard; one arriving right now is discarded too.
      fpc_d       = redirect_pc & ~XLEN'('h3);
      alloc_d     = '0;
      fill_d      = '0;
      head_d      = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      filled_d    = '0;
      drop_cnt_d  = drop_cnt_q + pend_cnt_q - CNT_W'(mem_rsp_valid & rsp_owed);
    end else begin
      if (req_fire) begin
        pc_d[alloc_q]     = fpc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PTR_W'(1);
        fpc_d             = fpc_q + XLEN'(4);
      end
      if (rsp_fill) begin
        data_d[fill_q]   = mem_rsp_data;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      if (inst_fire) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CNT_W'(req_fire) - CNT_W'(inst_fire);
      pend_cnt_d  = pend_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
      drop_cnt_d  = drop_cnt_q - CNT_W'(rsp_drop);
    end
  end

  // NOTE: the entry arrays are tiny, so they are reset as well; that is what pins inst/inst_pc to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q       <= RESET_PC;
      run_q       <= 1'b0;
      alloc_q     <= '0;
      fill_q      <= '0;
      head_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      pc_q        <= '{default: '0};
      data_q      <= '{default: '0};
      filled_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      fpc_q       <= fpc_d;
      run_q       <= 1'b1;
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      head_q      <= head_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      filled_q    <= filled_d;
    end
  end

  // A response with nothing outstanding means the memory broke one-response-per-request.
  rsp_expected_a: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> rsp_owed);

endmodule
